// File: rtl/qam_pll_pkg.sv
// rtl/qam_pll_pkg.sv - shared state enum and default window lengths for the PLL phase sequencer
package qam_pll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_VEC  = 3'd1,
    ST_GAP  = 3'd2,
    ST_ROT  = 3'd3,
    ST_TAIL = 3'd4,
    ST_HOLD = 3'd5
  } pll_seq_state_t;

  localparam int DEF_VEC_LEN = 16;
  localparam int DEF_GAP     = 1;
  localparam int DEF_ROT_LEN = 16;
  localparam int DEF_TAIL    = 8;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pll_phase_sequencer_if.sv
// rtl/pll_phase_sequencer_if.sv - symbol, CORDIC-enable and result handshake bundle
interface pll_phase_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic [WIDTH-1:0] phi_in;
  logic [WIDTH-1:0] x_out;
  logic [WIDTH-1:0] y_out;
  logic [WIDTH-1:0] phi_out;
  logic             ce_vec;
  logic             ce_rot;
  logic [WIDTH-1:0] e_in;
  logic [WIDTH-1:0] teta_in;
  logic [WIDTH-1:0] phi_res_in;
  logic [WIDTH-1:0] x_res_in;
  logic [WIDTH-1:0] y_res_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] teta;
  logic [WIDTH-1:0] phi;
  logic [WIDTH-1:0] x_o;
  logic [WIDTH-1:0] y_o;
  logic             busy;

  modport master (
    output in_valid, x_in, y_in, phi_in,
    input  in_ready, x_out, y_out, phi_out, ce_vec, ce_rot,
    output e_in, teta_in, phi_res_in, x_res_in, y_res_in, out_ready,
    input  out_valid, e, teta, phi, x_o, y_o, busy
  );

  modport slave (
    input  in_valid, x_in, y_in, phi_in,
    output in_ready, x_out, y_out, phi_out, ce_vec, ce_rot,
    input  e_in, teta_in, phi_res_in, x_res_in, y_res_in, out_ready,
    output out_valid, e, teta, phi, x_o, y_o, busy
  );

endinterface

// File: rtl/pll_seg_counter.sv
// rtl/pll_seg_counter.sv - loadable down-counter with terminal-count flag
module pll_seg_counter #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/pll_phase_sequencer.sv
// rtl/pll_phase_sequencer.sv - operand latch, CORDIC enable windows and result slot for the carrier-recovery PLL
module pll_phase_sequencer
  import qam_pll_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int GAP     = DEF_GAP,
  parameter int ROT_LEN = DEF_ROT_LEN,
  parameter int TAIL    = DEF_TAIL
) (
  input logic             clk,
  input logic             rst,
  pll_phase_sequencer_if.slave bus
);

  localparam int MAX_LEN  = max_of4(VEC_LEN, GAP, ROT_LEN, TAIL);
  localparam int CW       = $clog2(MAX_LEN + 1);
  localparam int GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

  pll_seq_state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    load_val;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_tc;
  logic             tail_last;
  logic             slot_free;
  logic             accept;
  logic             capture;
  logic             out_valid_q;
  logic [WIDTH-1:0] x_q, y_q, phi_q;
  logic [WIDTH-1:0] e_q, teta_q, phi_res_q, x_res_q, y_res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    load_val  = '0;
    tail_last = (state == ST_TAIL) && cnt_tc;
    slot_free = !out_valid_q || bus.out_ready;
    accept    = ((state == ST_IDLE) || (tail_last && slot_free)) && bus.in_valid;
    capture   = (tail_last && slot_free) || ((state == ST_HOLD) && bus.out_ready);

    case (state)
      ST_IDLE: if (bus.in_valid) state_n = ST_VEC;
      ST_VEC:  if (cnt_tc) state_n = (GAP > 0) ? ST_GAP : ST_ROT;
      ST_GAP:  if (cnt_tc) state_n = ST_ROT;
      ST_ROT:  if (cnt_tc) state_n = ST_TAIL;
      ST_TAIL: begin
        if (cnt_tc) begin
          if (!slot_free)         state_n = ST_HOLD;
          else if (bus.in_valid)  state_n = ST_VEC;
          else                    state_n = ST_IDLE;
        end
      end
      ST_HOLD: if (bus.out_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Each segment counts length-1 down to 0, so the terminal cycle is the last one of the window.
    case (state_n)
      ST_VEC:  load_val = CW'(VEC_LEN - 1);
      ST_GAP:  load_val = CW'(GAP_LOAD);
      ST_ROT:  load_val = CW'(ROT_LEN - 1);
      ST_TAIL: load_val = CW'(TAIL - 1);
      default: load_val = '0;
    endcase
  end

  assign cnt_load = (state_n != state);
  assign cnt_en   = (state != ST_IDLE) && (state != ST_HOLD);

  pll_seg_counter #(.CW(CW)) u_seg_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (load_val),
    .en       (cnt_en),
    .count    (cnt),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      phi_q <= '0;
    end else if (accept) begin
      x_q   <= bus.x_in;
      y_q   <= bus.y_in;
      phi_q <= bus.phi_in;
    end
  end

  // A capture wins over a same-cycle consume so the slot never shows a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      e_q         <= '0;
      teta_q      <= '0;
      phi_res_q   <= '0;
      x_res_q     <= '0;
      y_res_q     <= '0;
    end else if (capture) begin
      out_valid_q <= 1'b1;
      e_q         <= bus.e_in;
      teta_q      <= bus.teta_in;
      phi_res_q   <= bus.phi_res_in;
      x_res_q     <= bus.x_res_in;
      y_res_q     <= bus.y_res_in;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = (state == ST_IDLE) || (tail_last && slot_free);
  assign bus.ce_vec    = (state == ST_VEC);
  assign bus.ce_rot    = (state == ST_ROT);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign bus.phi_out   = phi_q;
  assign bus.out_valid = out_valid_q;
  assign bus.e         = e_q;
  assign bus.teta      = teta_q;
  assign bus.phi       = phi_res_q;
  assign bus.x_o       = x_res_q;
  assign bus.y_o       = y_res_q;

endmodule

// File: tb/tb_pll_phase_sequencer.sv
// tb/tb_pll_phase_sequencer.sv - self-checking bench for pll_phase_sequencer
module tb_pll_phase_sequencer;

  localparam int W   = 16;
  localparam int VL  = 16;
  localparam int G   = 1;
  localparam int RL  = 16;
  localparam int T   = 8;
  localparam int P   = VL + G + RL + T;
  localparam int VW  = 5 + 8 * W;
  localparam logic [VW-1:0] RST_VEC = {1'b1, {(VW-1){1'b0}}};

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  pll_phase_sequencer_if #(.WIDTH(W)) bus_a ();
  pll_phase_sequencer_if #(.WIDTH(W)) bus_b ();

  pll_phase_sequencer #(.WIDTH(W)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  pll_phase_sequencer #(.WIDTH(W), .VEC_LEN(4), .GAP(0), .ROT_LEN(3), .TAIL(1)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference: phase 0 idle, 1 running frame at cycle m_k since acceptance, 2 holding a result.
  int         m_phase = 0;
  int         m_k     = 0;
  int         m_acc   = 0;
  logic       m_ov    = 1'b0;
  logic [W-1:0] m_x = '0, m_y = '0, m_p = '0;
  logic [W-1:0] m_e = '0, m_t = '0, m_ph = '0, m_xo = '0, m_yo = '0;

  function automatic logic [VW-1:0] obs_a();
    return {bus_a.in_ready, bus_a.ce_vec, bus_a.ce_rot, bus_a.busy, bus_a.out_valid,
            bus_a.x_out, bus_a.y_out, bus_a.phi_out,
            bus_a.e, bus_a.teta, bus_a.phi, bus_a.x_o, bus_a.y_o};
  endfunction

  function automatic logic [VW-1:0] exp_a();
    logic rdy, cv, cr, bsy;
    rdy = 1'b0; cv = 1'b0; cr = 1'b0; bsy = 1'b1;
    if (m_phase == 0) begin
      rdy = 1'b1;
      bsy = 1'b0;
    end else if (m_phase == 1) begin
      cv  = (m_k >= 1) && (m_k <= VL);
      cr  = (m_k >= VL + G + 1) && (m_k <= VL + G + RL);
      rdy = (m_k == P) && (!m_ov || bus_a.out_ready);
    end
    return {rdy, cv, cr, bsy, m_ov, m_x, m_y, m_p, m_e, m_t, m_ph, m_xo, m_yo};
  endfunction

  task automatic a_drive(input logic iv, input logic ordy);
    @(negedge clk);
    bus_a.in_valid  = iv;
    bus_a.out_ready = ordy;
    bus_a.x_in      = W'($urandom);
    bus_a.y_in      = W'($urandom);
    bus_a.phi_in    = W'($urandom);
    if (m_phase != 2) begin
      bus_a.e_in       = W'($urandom);
      bus_a.teta_in    = W'($urandom);
      bus_a.phi_res_in = W'($urandom);
      bus_a.x_res_in   = W'($urandom);
      bus_a.y_res_in   = W'($urandom);
    end
  endtask

  task automatic a_edge();
    logic iv, ordy, last, sf, cap, acc;
    @(posedge clk);
    iv   = bus_a.in_valid;
    ordy = bus_a.out_ready;
    if (rst_a) begin
      m_phase = 0; m_k = 0; m_ov = 1'b0;
      m_x = '0; m_y = '0; m_p = '0;
      m_e = '0; m_t = '0; m_ph = '0; m_xo = '0; m_yo = '0;
      return;
    end
    last = (m_phase == 1) && (m_k == P);
    sf   = !m_ov || ordy;
    cap  = (last && sf) || ((m_phase == 2) && ordy);
    acc  = ((m_phase == 0) || (last && sf)) && iv;
    if (cap) begin
      m_ov = 1'b1;
      m_e = bus_a.e_in; m_t = bus_a.teta_in; m_ph = bus_a.phi_res_in;
      m_xo = bus_a.x_res_in; m_yo = bus_a.y_res_in;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    if (acc) begin
      m_x = bus_a.x_in; m_y = bus_a.y_in; m_p = bus_a.phi_in;
      m_phase = 1; m_k = 1; m_acc++;
    end else if (last) begin
      m_phase = sf ? 0 : 2;
    end else if (m_phase == 1) begin
      m_k++;
    end else if ((m_phase == 2) && ordy) begin
      m_phase = 0;
    end
  endtask

  task automatic test_reset();
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;
    bus_b.x_in = '0; bus_b.y_in = '0; bus_b.phi_in = '0;
    bus_b.e_in = '0; bus_b.teta_in = '0; bus_b.phi_res_in = '0;
    bus_b.x_res_in = '0; bus_b.y_res_in = '0;
    a_drive(1'b1, 1'b0);
    rst_a = 1'b1; rst_b = 1'b1;
    a_edge();
    a_drive(1'b0, 1'b0);
    rst_a = 1'b1;
    a_edge();
    a_drive(1'b0, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    compared++;
    if (obs_a() !== RST_VEC) begin
      mismatched++;
      $display("FAIL reset_a got=%h exp=%h", obs_a(), RST_VEC);
    end
    compared++;
    if ({bus_b.in_ready, bus_b.ce_vec, bus_b.ce_rot, bus_b.busy, bus_b.out_valid, bus_b.x_out, bus_b.e} !== {1'b1, 4'b0, {(2*W){1'b0}}}) begin
      mismatched++;
      $display("FAIL reset_b got=%b%b%b%b%b x=%h e=%h", bus_b.in_ready, bus_b.ce_vec, bus_b.ce_rot,
               bus_b.busy, bus_b.out_valid, bus_b.x_out, bus_b.e);
    end
    a_edge();
  endtask

  task automatic test_single();
    int first_ov = -1;
    logic [W-1:0] e41 = '0, t41 = '0;
    for (int c = 0; c <= 45; c++) begin
      a_drive(c == 0, 1'b1);
      if (c == 0) begin
        bus_a.x_in = 16'h1234; bus_a.y_in = 16'h0ABC; bus_a.phi_in = 16'h0100;
      end
      #1;
      compared++;
      if (obs_a() !== exp_a()) begin
        mismatched++;
        $display("FAIL single c=%0d got=%h exp=%h", c, obs_a(), exp_a());
      end
      if (c == 1) begin
        compared++;
        if ({bus_a.x_out, bus_a.y_out, bus_a.phi_out} !== {16'h1234, 16'h0ABC, 16'h0100}) begin
          mismatched++;
          $display("FAIL single_operands got=%h %h %h exp=1234 0abc 0100", bus_a.x_out, bus_a.y_out, bus_a.phi_out);
        end
      end
      if (c == 41) begin
        e41 = bus_a.e_in; t41 = bus_a.teta_in;
      end
      if (c == 42) begin
        compared++;
        if ({bus_a.e, bus_a.teta} !== {e41, t41}) begin
          mismatched++;
          $display("FAIL single_result got=%h %h exp=%h %h", bus_a.e, bus_a.teta, e41, t41);
        end
      end
      if ((first_ov < 0) && (bus_a.out_valid === 1'b1)) first_ov = c;
      a_edge();
    end
    compared++;
    if (first_ov != 42) begin
      mismatched++;
      $display("FAIL single_ov_rise got=%0d exp=42", first_ov);
    end
  endtask

  task automatic test_back_to_back();
    int last_acc = -1;
    int n_acc = 0;
    int guard = 0;
    for (int c = 0; c <= 3 * P + 1; c++) begin
      a_drive(1'b1, 1'b1);
      #1;
      compared++;
      if (obs_a() !== exp_a()) begin
        mismatched++;
        $display("FAIL b2b c=%0d got=%h exp=%h", c, obs_a(), exp_a());
      end
      if (bus_a.in_ready === 1'b1) begin
        if (last_acc >= 0) begin
          compared++;
          if (c - last_acc != P) begin
            mismatched++;
            $display("FAIL b2b_spacing got=%0d exp=%0d", c - last_acc, P);
          end
        end
        last_acc = c;
        n_acc++;
      end
      a_edge();
    end
    compared++;
    if (n_acc != 4) begin
      mismatched++;
      $display("FAIL b2b_count got=%0d exp=4", n_acc);
    end
    while (((m_phase != 0) || m_ov) && (guard < 100)) begin
      a_drive(1'b0, 1'b1);
      #1;
      compared++;
      if (obs_a() !== exp_a()) begin
        mismatched++;
        $display("FAIL b2b_drain got=%h exp=%h", obs_a(), exp_a());
      end
      a_edge();
      guard++;
    end
    if (guard >= 100) begin
      mismatched++;
      $display("FAIL b2b_drain_timeout got=%0d exp=<100", guard);
    end
  endtask

  task automatic test_backpressure();
    int base = m_acc;
    int guard = 0;
    logic [W-1:0] held_e;
    while ((m_phase != 2) && (guard < 200)) begin
      a_drive((m_acc - base) < 2, 1'b0);
      #1;
      compared++;
      if (obs_a() !== exp_a()) begin
        mismatched++;
        $display("FAIL bp c=%0d got=%h exp=%h", guard, obs_a(), exp_a());
      end
      a_edge();
      guard++;
    end
    compared++;
    if (guard >= 200) begin
      mismatched++;
      $display("FAIL bp_hold_timeout got=%0d exp=<200", guard);
    end
    for (int c = 0; c < 3; c++) begin
      a_drive(1'b0, 1'b0);
      #1;
      compared++;
      if ({bus_a.in_ready, bus_a.busy, bus_a.ce_vec, bus_a.ce_rot} !== 4'b0100) begin
        mismatched++;
        $display("FAIL bp_hold got=%b exp=0100", {bus_a.in_ready, bus_a.busy, bus_a.ce_vec, bus_a.ce_rot});
      end
      a_edge();
    end
    a_drive(1'b0, 1'b1);
    held_e = bus_a.e_in;
    #1;
    compared++;
    if (obs_a() !== exp_a()) begin
      mismatched++;
      $display("FAIL bp_release got=%h exp=%h", obs_a(), exp_a());
    end
    a_edge();
    a_drive(1'b0, 1'b0);
    #1;
    compared++;
    if ({bus_a.busy, bus_a.out_valid, bus_a.in_ready, bus_a.e} !== {1'b0, 1'b1, 1'b1, held_e}) begin
      mismatched++;
      $display("FAIL bp_after got=%b%b%b e=%h exp=011 e=%h", bus_a.busy, bus_a.out_valid, bus_a.in_ready, bus_a.e, held_e);
    end
    a_edge();
  endtask

  task automatic test_mid_reset();
    for (int c = 0; c <= 22; c++) begin
      a_drive(c == 0, 1'b0);
      rst_a = (c == 20);
      #1;
      compared++;
      if (obs_a() !== exp_a()) begin
        mismatched++;
        $display("FAIL midrst c=%0d got=%h exp=%h", c, obs_a(), exp_a());
      end
      if (c == 20) begin
        compared++;
        if ({bus_a.ce_rot, bus_a.out_valid} !== 2'b11) begin
          mismatched++;
          $display("FAIL midrst_pre got=%b%b exp=11", bus_a.ce_rot, bus_a.out_valid);
        end
      end
      if (c == 21) begin
        compared++;
        if (obs_a() !== RST_VEC) begin
          mismatched++;
          $display("FAIL midrst_post got=%h exp=%h", obs_a(), RST_VEC);
        end
      end
      a_edge();
    end
    rst_a = 1'b0;
  endtask

  task automatic test_random();
    int guard = 0;
    for (int c = 0; c < 700; c++) begin
      a_drive($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      #1;
      compared++;
      if (obs_a() !== exp_a()) begin
        mismatched++;
        $display("FAIL random c=%0d got=%h exp=%h", c, obs_a(), exp_a());
      end
      a_edge();
    end
    while (((m_phase != 0) || m_ov) && (guard < 100)) begin
      a_drive(1'b0, 1'b1);
      #1;
      compared++;
      if (obs_a() !== exp_a()) begin
        mismatched++;
        $display("FAIL random_drain got=%h exp=%h", obs_a(), exp_a());
      end
      a_edge();
      guard++;
    end
    if (guard >= 100) begin
      mismatched++;
      $display("FAIL random_drain_timeout got=%0d exp=<100", guard);
    end
  endtask

  task automatic test_short_config();
    logic [4:0]   want;
    logic [W-1:0] xs = '0, e8 = '0, y8 = '0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      bus_b.in_valid   = (c == 0);
      bus_b.out_ready  = 1'b1;
      bus_b.x_in       = W'($urandom);
      bus_b.y_in       = W'($urandom);
      bus_b.phi_in     = W'($urandom);
      bus_b.e_in       = W'($urandom);
      bus_b.teta_in    = W'($urandom);
      bus_b.phi_res_in = W'($urandom);
      bus_b.x_res_in   = W'($urandom);
      bus_b.y_res_in   = W'($urandom);
      if (c == 0) xs = bus_b.x_in;
      if (c == 8) begin
        e8 = bus_b.e_in; y8 = bus_b.y_res_in;
      end
      #1;
      want = {(c == 0) || (c >= 8), (c >= 1) && (c <= 4), (c >= 5) && (c <= 7), (c >= 1) && (c <= 8), c == 9};
      compared++;
      if ({bus_b.in_ready, bus_b.ce_vec, bus_b.ce_rot, bus_b.busy, bus_b.out_valid} !== want) begin
        mismatched++;
        $display("FAIL short c=%0d got=%b exp=%b", c, {bus_b.in_ready, bus_b.ce_vec, bus_b.ce_rot, bus_b.busy, bus_b.out_valid}, want);
      end
      if (c == 9) begin
        compared++;
        if ({bus_b.x_out, bus_b.e, bus_b.y_o} !== {xs, e8, y8}) begin
          mismatched++;
          $display("FAIL short_data got=%h %h %h exp=%h %h %h", bus_b.x_out, bus_b.e, bus_b.y_o, xs, e8, y8);
        end
      end
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_random();
    test_short_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pll_phase_sequencer.md
# pll_phase_sequencer

Parametrised sequencing and operand/result latch for the carrier-recovery PLL in the QAM-16 receiver. Accepts one (x, y, phi) symbol per frame over a valid/ready handshake, holds it stable for the CORDIC vectoring and rotation cores, and generates their clock enables from programmable window lengths. Captures the PLL results into a registered output slot with its own valid/ready handshake, stalling the sequence rather than dropping results under back-pressure. Sits between the symbol front end and the loop filter / slicer.

## Interface
- `WIDTH`, 16, data width of every operand and result bus.
- `VEC_LEN`, 16, cycles `ce_vec` is high per frame (≥1).
- `GAP`, 1, idle cycles between the vectoring and rotation windows (≥0; 0 skips the gap).
- `ROT_LEN`, 16, cycles `ce_rot` is high per frame (≥1).
- `TAIL`, 8, settle cycles after the rotation window before result capture (≥1).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  symbol operands present.
- `in_ready`  out  1  sequencer can accept a symbol.
- `x_in`, `y_in`, `phi_in`  in  WIDTH  symbol operands.
- `x_out`, `y_out`, `phi_out`  out  WIDTH  latched operands to the CORDIC cores.
- `ce_vec`, `ce_rot`  out  1  vectoring / rotation core enables.
- `e_in`, `teta_in`, `phi_res_in`, `x_res_in`, `y_res_in`  in  WIDTH  PLL results.
- `out_valid`  out  1  result slot full.
- `out_ready`  in  1  consumer takes the result.
- `e`, `teta`, `phi`, `x_o`, `y_o`  out  WIDTH  registered results.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, VEC, GAP, ROT, TAIL, HOLD. One down-counter, width `$clog2(max(VEC_LEN,GAP,ROT_LEN,TAIL)+1)`, loaded on each state entry with the segment length minus 1.
- IDLE: `in_ready`=1. On `in_valid`: latch `x_in/y_in/phi_in` into `x_out/y_out/phi_out` and go to VEC.
- VEC → GAP, or → ROT if GAP=0, when the counter reaches 0. GAP → ROT. ROT → TAIL.
- TAIL, last cycle:
  - Slot free (`!out_valid || out_ready`): capture all five results and set `out_valid`.
  - Then go to VEC if `in_valid` (accepting a new symbol, zero bubble); otherwise go to IDLE.
  - Slot occupied and `out_ready`=0: go to HOLD.
- HOLD: `ce_*`=0 and operands frozen. On `out_ready`, capture results (the result inputs are assumed held by the cores while enables are low) and go to IDLE.
- `in_ready`=1 only in IDLE, or in the last TAIL cycle with the slot free.
- `out_valid` clears on `out_ready` unless a capture occurs in the same cycle; a capture has priority and keeps `out_valid`=1.
- `ce_vec`=1 exactly in VEC and `ce_rot`=1 exactly in ROT; both are decoded from the registered state, so they are glitch-free.
- Operand registers change only on acceptance. Result registers change only on capture.

## Timing
- Reset: state IDLE; `x_out`, `y_out`, `phi_out`, `e`, `teta`, `phi`, `x_o`, `y_o` = 0; `ce_vec`=`ce_rot`=`out_valid`=`busy`=0; `in_ready`=1.
- Acceptance edge = cycle 0. Cycle boundaries:
  - `ce_vec` high in cycles 1..VEC_LEN.
  - `ce_rot` high in cycles VEC_LEN+GAP+1..VEC_LEN+GAP+ROT_LEN.
  - Results are sampled at the edge ending cycle P = VEC_LEN+GAP+ROT_LEN+TAIL; `out_valid` is high from cycle P+1.
- Defaults give P=41. Sustained throughput is one symbol per P cycles when the consumer keeps up.
- Reset mid-frame: on the next edge, return to IDLE, drop both enables, clear `out_valid`, and discard any pending result.
- Simultaneous `out_ready` and capture in the last TAIL cycle: the old result is consumed and the new one is loaded, with no bubble in `out_valid`.

## Structure
- Shared package `qam_pll_pkg`: the state enum `pll_seq_state_t` and the default window constants (16/1/16/8).
- One sub-module, `pll_seg_counter`: a loadable down-counter with a terminal-count flag, parametrised by width.
- All other logic lives in the top module.

## Test plan
- Defaults, one symbol (x=0x1234, y=0x0ABC, phi=0x0100), `out_ready`=1 → `ce_vec` high in cycles 1–16, `ce_rot` high in cycles 18–33, `out_valid` rises in cycle 42 with the result values presented in cycle 41.
- `in_valid` held high continuously → acceptances every 41 cycles, `ce_vec` restarts in cycle 42 with no IDLE bubble, and operands update only at acceptance.
- `out_ready`=0 across two frames → the second frame enters HOLD after its TAIL, and `in_ready`=0. Raising `out_ready` for 1 cycle → second results captured, IDLE next cycle.
- GAP=0, VEC_LEN=4, ROT_LEN=3, TAIL=1 → `ce_vec` in cycles 1–4, `ce_rot` in cycles 5–7, `out_valid` in cycle 9.
- `rst` asserted in cycle 20 (inside ROT) → `ce_rot`=0 and state IDLE in cycle 21, `out_valid`=0, and all outputs at reset values.
